// File: rtl/ysyx_041514_if_fetch_pkg.sv
// ============================================================================
// Module   : ysyx_041514_if_fetch_pkg
// Purpose  : Shared constants for the instruction-fetch stage: the NOP
//            encoding, fetch-exception bit positions and parameter defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_041514_if_fetch_pkg;

  // addi x0, x0, 0 -- handed to decode in place of a faulting instruction
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Bit positions inside the 2-bit fetch exception code
  localparam int IFEXC_MISALIGN = 1;
  localparam int IFEXC_ACCESS   = 0;

  // Fetch-stage parameter defaults
  localparam int IF_XLEN       = 64;
  localparam int IF_ADDR_W     = 32;
  localparam int IF_MAX_OUTST  = 2;
  localparam int IF_FIFO_DEPTH = 2;

  function automatic logic [1:0] exc_code(input logic misalign, input logic access);
    logic [1:0] e;
    e                 = 2'b00;
    e[IFEXC_MISALIGN] = misalign;
    e[IFEXC_ACCESS]   = access;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_041514_if_fetch_if.sv
// ============================================================================
// Module   : ysyx_041514_if_fetch_if
// Purpose  : Bundle of every fetch-stage bus: PC register side (pc_next_i,
//            flush_i, fetch_stall_o), icache request/response channel and the
//            decode-side valid/ready output.
//            master : the fetch stage itself
//            slave  : the surrounding pipeline / icache / decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_041514_if_fetch_if
  import ysyx_041514_if_fetch_pkg::*;
#(
  parameter int XLEN   = IF_XLEN,
  parameter int ADDR_W = IF_ADDR_W
);

  // PC register side
  logic [ADDR_W-1:0] pc_next_i;
  logic              flush_i;
  logic              fetch_stall_o;
  // icache request
  logic              icache_req_valid_o;
  logic              icache_req_ready_i;
  logic [ADDR_W-1:0] icache_req_addr_o;
  // icache response
  logic              icache_resp_valid_i;
  logic [31:0]       icache_resp_data_i;
  logic              icache_resp_err_i;
  // decode side
  logic              if_valid_o;
  logic              if_ready_i;
  logic [XLEN-1:0]   if_pc_o;
  logic [31:0]       if_inst_o;
  logic [1:0]        if_exc_o;

  modport master (
    input  pc_next_i, flush_i, icache_req_ready_i,
    input  icache_resp_valid_i, icache_resp_data_i, icache_resp_err_i,
    input  if_ready_i,
    output fetch_stall_o, icache_req_valid_o, icache_req_addr_o,
    output if_valid_o, if_pc_o, if_inst_o, if_exc_o
  );

  modport slave (
    output pc_next_i, flush_i, icache_req_ready_i,
    output icache_resp_valid_i, icache_resp_data_i, icache_resp_err_i,
    output if_ready_i,
    input  fetch_stall_o, icache_req_valid_o, icache_req_addr_o,
    input  if_valid_o, if_pc_o, if_inst_o, if_exc_o
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_041514_if_fetch_sync_fifo.sv
// ============================================================================
// Module   : ysyx_041514_sync_fifo
// Purpose  : Small synchronous FIFO with registered storage (no bypass).
//            Ports: clk, rst_n (async, active low), clr (sync clear),
//            push/din, pop/dout (head entry), full, empty, cnt.
//            Storage resets to zero so dout is zero out of reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_041514_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only honoured when the head leaves the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ysyx_041514_if_fetch.sv
// ============================================================================
// Module   : ysyx_041514_if_fetch
// Purpose  : Instruction-fetch stage. Issues pc_next_i to the icache under a
//            credit rule, tags in-flight requests with their PC, buffers
//            returned instructions for decode, drops responses killed by a
//            flush and stalls the PC register when no fetch is accepted.
// Ports    : clk, rst_n (async, active low) and bus (master modport of
//            ysyx_041514_if_fetch_if: PC side, icache channel, decode side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_041514_if_fetch
  import ysyx_041514_if_fetch_pkg::*;
#(
  parameter int XLEN       = IF_XLEN,
  parameter int ADDR_W     = IF_ADDR_W,
  parameter int MAX_OUTST  = IF_MAX_OUTST,
  parameter int FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_041514_if_fetch_if.master bus
);

  localparam int CTR_W  = $clog2(MAX_OUTST) + 1;
  localparam int TCNT_W = $clog2(MAX_OUTST + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W  = XLEN + 32 + 2;

  logic [CTR_W-1:0]  outst;
  logic [CTR_W-1:0]  outst_nxt;
  logic [CTR_W-1:0]  kill;
  logic [CTR_W-1:0]  kill_nxt;

  logic              aligned;
  logic              can_issue;
  logic              req_valid;
  logic              icache_fire;
  logic              mis_push;
  logic              fire;
  logic              resp_take;
  logic              resp_drop;
  logic              out_push_req;
  logic              out_push;
  logic              out_pop;
  logic              out_full;
  logic              out_empty;
  logic [FCNT_W-1:0] out_cnt;
  logic [OUT_W-1:0]  out_din;
  logic [OUT_W-1:0]  out_dout;
  logic [31:0]       credit_used;

  logic [ADDR_W-1:0] tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [TCNT_W-1:0] tag_cnt;

  logic [XLEN-1:0]   push_pc;
  logic [31:0]       push_inst;
  logic [1:0]        push_exc;

  // ---------------- issue ----------------
  assign out_pop = ~out_empty & bus.if_ready_i;
  assign aligned = (bus.pc_next_i[1:0] == 2'b00);

  // The tag queue holds exactly the outstanding requests, so its occupancy
  // doubles as the outstanding count in the credit sum.
  assign credit_used = 32'(tag_cnt) + 32'(out_cnt) - 32'(out_pop);
  assign can_issue   = ~tag_full && (credit_used < 32'(FIFO_DEPTH));

  assign req_valid   = rst_n & ~bus.flush_i & can_issue & aligned;
  assign icache_fire = req_valid & bus.icache_req_ready_i;

  // A misaligned PC bypasses the icache, but only once the pipe has drained
  // so that the exception entry stays in program order.
  assign mis_push = rst_n & ~bus.flush_i & can_issue & ~aligned & (outst == '0);
  assign fire     = icache_fire | mis_push;

  // ---------------- response ----------------
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_take = bus.icache_resp_valid_i & ~tag_empty;
  assign resp_drop = resp_take & ((kill != '0) | bus.flush_i);

  assign out_push_req = (resp_take & ~resp_drop) | mis_push;
  assign out_push     = out_push_req & (~out_full | out_pop);

  always_comb begin
    push_pc = '0;
    if (mis_push) begin
      push_pc[ADDR_W-1:0] = bus.pc_next_i;
      push_inst           = INST_NOP;
      push_exc            = exc_code(1'b1, 1'b0);
    end else begin
      push_pc[ADDR_W-1:0] = tag_head;
      push_inst           = bus.icache_resp_err_i ? INST_NOP : bus.icache_resp_data_i;
      push_exc            = exc_code(1'b0, bus.icache_resp_err_i);
    end
  end

  assign out_din = {push_pc, push_inst, push_exc};

  // ---------------- counters ----------------
  assign outst_nxt = outst + CTR_W'(icache_fire) - CTR_W'(resp_take);

  // Killed requests stay counted in outst until their response returns, so a
  // flush simply marks everything still in flight after this cycle as killed
  // (no request can issue during the flush cycle).
  always_comb begin
    kill_nxt = kill;
    if (bus.flush_i) begin
      kill_nxt = outst_nxt;
    end else if (resp_drop) begin
      kill_nxt = kill - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
      kill  <= '0;
    end else begin
      outst <= outst_nxt;
      kill  <= kill_nxt;
    end
  end

  // ---------------- storage ----------------
  ysyx_041514_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .push  (icache_fire),
    .din   (bus.pc_next_i),
    .pop   (resp_take),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .cnt   (tag_cnt)
  );

  ysyx_041514_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush_i),
    .push  (out_push),
    .din   (out_din),
    .pop   (out_pop),
    .dout  (out_dout),
    .full  (out_full),
    .empty (out_empty),
    .cnt   (out_cnt)
  );

  // ---------------- outputs ----------------
  assign bus.fetch_stall_o      = ~fire;
  assign bus.icache_req_valid_o = req_valid;
  assign bus.icache_req_addr_o  = bus.pc_next_i;
  assign bus.if_valid_o         = ~out_empty;
  assign bus.if_pc_o            = out_dout[OUT_W-1 -: XLEN];
  assign bus.if_inst_o          = out_dout[33:2];
  assign bus.if_exc_o           = out_dout[1:0];

endmodule

`default_nettype wire

// File: tb/tb_ysyx_041514_if_fetch.sv
// ============================================================================
// Module   : tb_ysyx_041514_if_fetch
// Purpose  : Directed self-checking bench for ysyx_041514_if_fetch with a
//            small in-order icache responder and a PC register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_041514_if_fetch;

  logic clk = 1'b0;
  logic rst_n;

  ysyx_041514_if_fetch_if #(.XLEN(64), .ADDR_W(32)) bus ();

  ysyx_041514_if_fetch #(
    .XLEN       (64),
    .ADDR_W     (32),
    .MAX_OUTST  (2),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc;
  logic [31:0] err_addr;
  logic [31:0] icq[$];
  logic        auto_resp;
  logic        resp_once;
  int          fires;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Pushes into a full output buffer without a pop must never be requested
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.out_push_req && dut.out_full && !dut.out_pop)
      check("fifo_overflow", 64'd1, 64'd0);
  end

  // One clock: models the icache (1-cycle latency, in order) and the PC register
  task automatic tick();
    logic        fire_now;
    logic [31:0] addr_now;
    logic        adv;
    logic [31:0] a;
    #1;
    fire_now = bus.icache_req_valid_o & bus.icache_req_ready_i;
    addr_now = bus.icache_req_addr_o;
    adv      = ~bus.fetch_stall_o;
    @(posedge clk);
    if (fire_now) icq.push_back(addr_now);
    if (adv) pc = pc + 32'd4;
    #1;
    if ((auto_resp || resp_once) && icq.size() > 0) begin
      a = icq.pop_front();
      bus.icache_resp_valid_i = 1'b1;
      bus.icache_resp_data_i  = inst_of(a);
      bus.icache_resp_err_i   = (a == err_addr);
    end else begin
      bus.icache_resp_valid_i = 1'b0;
      bus.icache_resp_data_i  = 32'h0;
      bus.icache_resp_err_i   = 1'b0;
    end
    resp_once     = 1'b0;
    bus.pc_next_i = pc;
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst_n                   = 1'b0;
    icq.delete();
    auto_resp               = 1'b0;
    resp_once               = 1'b0;
    err_addr                = 32'hFFFF_FFFF;
    pc                      = start_pc;
    bus.pc_next_i           = start_pc;
    bus.flush_i             = 1'b0;
    bus.icache_req_ready_i  = 1'b1;
    bus.icache_resp_valid_i = 1'b0;
    bus.icache_resp_data_i  = 32'h0;
    bus.icache_resp_err_i   = 1'b0;
    bus.if_ready_i          = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (!bus.if_valid_o && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.if_valid_o), 64'd1);
  endtask

  initial begin
    // ---- reset values ----
    rst_n = 1'b0;
    bus.pc_next_i = 32'h8000_0000; bus.flush_i = 1'b0;
    bus.icache_req_ready_i = 1'b1; bus.icache_resp_valid_i = 1'b0;
    bus.icache_resp_data_i = 32'h0; bus.icache_resp_err_i = 1'b0;
    bus.if_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall",     64'(bus.fetch_stall_o),      64'd1);
    check("rst_req_valid", 64'(bus.icache_req_valid_o), 64'd0);
    check("rst_if_valid",  64'(bus.if_valid_o),         64'd0);
    check("rst_if_pc",     bus.if_pc_o,                 64'd0);
    check("rst_if_inst",   64'(bus.if_inst_o),          64'd0);
    check("rst_if_exc",    64'(bus.if_exc_o),           64'd0);

    // ---- 1: streaming fetch, one instruction per cycle ----
    do_reset(32'h8000_0000);
    auto_resp = 1'b1;
    check("t1_req_addr", 64'(bus.icache_req_addr_o), 64'h8000_0000);
    check("t1_stall0",   64'(bus.fetch_stall_o),     64'd0);
    wait_valid("t1_valid", 10);
    for (int k = 0; k < 4; k++) begin
      check("t1_pc",    bus.if_pc_o,              64'h8000_0000 + 64'(4 * k));
      check("t1_inst",  64'(bus.if_inst_o),       64'(inst_of(32'h8000_0000 + 32'(4 * k))));
      check("t1_stall", 64'(bus.fetch_stall_o),   64'd0);
      tick();
    end

    // ---- 2: decode stalled: two fetches then stall, drain in order ----
    do_reset(32'h8000_0000);
    auto_resp = 1'b1;
    bus.if_ready_i = 1'b0;
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      if (!bus.fetch_stall_o) fires++;
      tick();
    end
    check("t2_fires",     64'(fires),               64'd2);
    check("t2_stall",     64'(bus.fetch_stall_o),   64'd1);
    check("t2_hold_pc",   bus.if_pc_o,              64'h8000_0000);
    tick();
    check("t2_hold_pc2",  bus.if_pc_o,              64'h8000_0000);
    check("t2_hold_v",    64'(bus.if_valid_o),      64'd1);
    bus.if_ready_i = 1'b1;
    tick();
    check("t2_drain_pc1", bus.if_pc_o,              64'h8000_0004);
    tick();
    check("t2_drain_pc2", bus.if_pc_o,              64'h8000_0008);

    // ---- 3: flush with two requests in flight ----
    do_reset(32'h8000_0000);
    tick();
    tick();
    check("t3_stall_full", 64'(bus.fetch_stall_o), 64'd1);
    bus.flush_i = 1'b1;
    #1;
    check("t3_req_in_flush", 64'(bus.icache_req_valid_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    pc = 32'h8000_0100;
    bus.pc_next_i = pc;
    auto_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t3_no_valid", 64'(bus.if_valid_o), 64'd0);
      tick();
    end
    wait_valid("t3_valid", 10);
    check("t3_new_pc",   bus.if_pc_o,        64'h8000_0100);
    check("t3_new_inst", 64'(bus.if_inst_o), 64'(inst_of(32'h8000_0100)));

    // ---- 4: flush in the same cycle as a response ----
    do_reset(32'h8000_0000);
    tick();
    resp_once = 1'b1;
    tick();
    check("t4_resp_in_flush", 64'(bus.icache_resp_valid_i), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    pc = 32'h8000_0200;
    bus.pc_next_i = pc;
    auto_resp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t4_no_valid", 64'(bus.if_valid_o), 64'd0);
    end
    wait_valid("t4_valid", 10);
    check("t4_new_pc", bus.if_pc_o, 64'h8000_0200);

    // ---- 5: misaligned PC, nothing in flight ----
    do_reset(32'h8000_0002);
    bus.if_ready_i = 1'b0;
    check("t5_no_req", 64'(bus.icache_req_valid_o), 64'd0);
    check("t5_accept", 64'(bus.fetch_stall_o),      64'd0);
    tick();
    check("t5_valid",  64'(bus.if_valid_o),         64'd1);
    check("t5_pc",     bus.if_pc_o,                 64'h8000_0002);
    check("t5_exc",    64'(bus.if_exc_o),           64'd2);
    check("t5_inst",   64'(bus.if_inst_o),          64'h13);

    // ---- 6: access fault, then reset mid-flight ----
    do_reset(32'h8000_0010);
    err_addr  = 32'h8000_0010;
    auto_resp = 1'b1;
    wait_valid("t6_valid", 10);
    check("t6_pc",    bus.if_pc_o,        64'h8000_0010);
    check("t6_exc",   64'(bus.if_exc_o),  64'd1);
    check("t6_inst",  64'(bus.if_inst_o), 64'h13);
    tick();
    check("t6_pc2",   bus.if_pc_o,        64'h8000_0014);
    check("t6_exc2",  64'(bus.if_exc_o),  64'd0);
    check("t6_inst2", 64'(bus.if_inst_o), 64'(inst_of(32'h8000_0014)));
    rst_n = 1'b0;
    #1;
    check("t6_arst_if_valid",  64'(bus.if_valid_o),         64'd0);
    check("t6_arst_req_valid", 64'(bus.icache_req_valid_o), 64'd0);
    check("t6_arst_stall",     64'(bus.fetch_stall_o),      64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
